// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register driving an async-read instruction memory,
// plus the IF/ID pipeline register with stall, flush, branch redirect and a fetch counter.
module fetch_stage #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic [N-1:0]     PCBranch,
  input  logic             stall,
  input  logic             flush,
  output logic [N-1:0]     imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [N-1:0]     if_pc,
  output logic [31:0]      if_instr,
  output logic             if_valid,
  output logic [CNT_W-1:0] fetch_count
);

  logic [N-1:0]     pc_q, pc_d;
  logic [N-1:0]     if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic             if_valid_q, if_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Redirect beats stall; the sequential increment wraps naturally at 2^N.
  always_comb begin
    pc_d = pc_q + N'(4);
    if (PCSrc) begin
      pc_d = {PCBranch[N-1:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // A taken branch squashes the wrong-path word currently on imem_rdata.
  always_comb begin
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
    if (flush || PCSrc) begin
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      if_pc_d    = pc_q;
      if_instr_d = imem_rdata;
      if_valid_d = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized stall/flush/branch run,
// with captured IF/ID entries checked against an expected queue.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, PCSrc, stall, flush;
  logic [63:0] PCBranch;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  // Instruction memory returns the low word of its address.
  assign imem_rdata = imem_addr[31:0];

  fetch_stage #(.N(64), .RESET_PC(64'd0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCBranch(PCBranch),
    .stall(stall), .flush(flush), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .fetch_count(fetch_count)
  );

  int          checks = 0;
  int          failures = 0;
  logic [95:0] exp_q[$];   // {pc, instr} of each expected IF/ID capture
  logic [95:0] e;
  logic [63:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  logic        m_valid = 1'b0;
  logic [63:0] m_ifpc = '0;
  logic [31:0] m_ifinstr = '0;
  logic        m_cap = 1'b0;

  // Drives one cycle of inputs, updates the reference model, and advances past the edge.
  task automatic drive_cycle(input logic rst, input logic pcsrc, input logic [63:0] br,
                             input logic st, input logic fl);
    reset = rst; PCSrc = pcsrc; PCBranch = br; stall = st; flush = fl;
    m_cap = !rst && !pcsrc && !fl && !st;
    if (rst) begin
      m_valid = 1'b0; m_ifpc = '0; m_ifinstr = '0; m_cnt = '0;
      exp_q.delete();
    end else if (pcsrc || fl) begin
      m_valid = 1'b0; m_ifpc = '0; m_ifinstr = '0;
    end else if (!st) begin
      exp_q.push_back({m_pc, m_pc[31:0]});
      m_valid = 1'b1; m_ifpc = m_pc; m_ifinstr = m_pc[31:0];
      m_cnt = m_cnt + 32'd1;
    end
    if (rst) m_pc = 64'd0;
    else if (pcsrc) m_pc = {br[63:2], 2'b00};
    else if (!st) m_pc = m_pc + 64'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 64'h55, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++; if (imem_addr !== 64'd0) begin failures++; $display("FAIL reset_pc: got %h want 0", imem_addr); end
    checks++; if (if_pc !== 64'd0) begin failures++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'd0) begin failures++; $display("FAIL reset_if_instr: got %h want 0", if_instr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL free_run_queue: expected entry missing at step %0d", i);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e[95:32] || if_instr !== e[31:0] || if_valid !== 1'b1) begin
          failures++;
          $display("FAIL free_run_capture: got pc=%h instr=%h v=%b want pc=%h instr=%h v=1",
                   if_pc, if_instr, if_valid, e[95:32], e[31:0]);
        end
      end
      checks++; if (if_pc !== 64'(i * 4)) begin failures++; $display("FAIL free_run_if_pc: got %h want %h", if_pc, i * 4); end
    end
    checks++; if (imem_addr !== 64'd8) begin failures++; $display("FAIL free_run_pc: got %h want 8", imem_addr); end
    checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL free_run_count: got %0d want 2", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      checks++; if (imem_addr !== 64'd8) begin failures++; $display("FAIL stall_pc: got %h want 8", imem_addr); end
      checks++; if (if_pc !== 64'd4 || if_instr !== 32'd4 || if_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold: got pc=%h instr=%h v=%b want pc=4 instr=4 v=1", if_pc, if_instr, if_valid);
      end
      checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count: got %0d want 2", fetch_count); end
    end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL stall_resume_queue: expected entry missing");
    end else begin
      e = exp_q.pop_front();
      if (if_pc !== e[95:32] || if_instr !== e[31:0]) begin
        failures++; $display("FAIL stall_resume: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, e[95:32], e[31:0]);
      end
    end
    checks++; if (if_pc !== 64'd8) begin failures++; $display("FAIL stall_resume_pc: got %h want 8", if_pc); end
    checks++; if (imem_addr !== 64'd12) begin failures++; $display("FAIL stall_resume_next: got %h want c", imem_addr); end
  endtask

  task automatic test_branch();
    drive_cycle(1'b0, 1'b1, 64'h103, 1'b0, 1'b0);
    checks++; if (imem_addr !== 64'h100) begin failures++; $display("FAIL branch_pc: got %h want 100", imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 64'd0) begin
      failures++; $display("FAIL branch_bubble: got pc=%h instr=%h v=%b want all 0", if_pc, if_instr, if_valid);
    end
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL branch_count: got %0d want 3", fetch_count); end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL branch_target_queue: expected entry missing");
    end else begin
      e = exp_q.pop_front();
      if (if_pc !== e[95:32] || if_instr !== e[31:0] || if_valid !== 1'b1) begin
        failures++; $display("FAIL branch_target: got pc=%h instr=%h v=%b want pc=%h instr=%h v=1",
                             if_pc, if_instr, if_valid, e[95:32], e[31:0]);
      end
    end
    checks++; if (if_pc !== 64'h100) begin failures++; $display("FAIL branch_target_pc: got %h want 100", if_pc); end
    checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL branch_target_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_flush();
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
    checks++; if (imem_addr !== 64'h104) begin failures++; $display("FAIL flush_stall_pc: got %h want 104", imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_pc !== 64'd0) begin
      failures++; $display("FAIL flush_stall_bubble: got pc=%h v=%b want pc=0 v=0", if_pc, if_valid);
    end
    checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL flush_stall_count: got %0d want 4", fetch_count); end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (imem_addr !== 64'h108) begin failures++; $display("FAIL flush_pc: got %h want 108", imem_addr); end
    checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd4) begin
      failures++; $display("FAIL flush_bubble: got v=%b count=%0d want v=0 count=4", if_valid, fetch_count);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_target: got %h want fffffffffffffffc", imem_addr); end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_if_top: got pc=%h instr=%h want pc=fffffffffffffffc instr=fffffffc", if_pc, if_instr);
    end
    checks++; if (imem_addr !== 64'd0) begin failures++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++; if (if_pc !== 64'd0 || if_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_if_zero: got pc=%h v=%b want pc=0 v=1", if_pc, if_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic st, fl, br_en;
    logic [63:0] br;
    for (int i = 0; i < 60; i++) begin
      st    = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 5) == 0);
      br_en = ($urandom_range(0, 7) == 0);
      br    = {$urandom(), $urandom()};
      drive_cycle(1'b0, br_en, br, st, fl);
      checks++; if (imem_addr !== m_pc) begin failures++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, imem_addr, m_pc); end
      checks++; if (fetch_count !== m_cnt) begin failures++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, fetch_count, m_cnt); end
      checks++; if (if_valid !== m_valid) begin failures++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, if_valid, m_valid); end
      checks++;
      if (m_cap) begin
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_queue[%0d]: expected entry missing", i);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e[95:32] || if_instr !== e[31:0]) begin
            failures++; $display("FAIL b2b_capture[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                                 i, if_pc, if_instr, e[95:32], e[31:0]);
          end
        end
      end else if (if_pc !== m_ifpc || if_instr !== m_ifinstr) begin
        failures++; $display("FAIL b2b_hold[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                             i, if_pc, if_instr, m_ifpc, m_ifinstr);
      end
    end
  endtask

  task automatic test_reset_mid_branch();
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 64'h200, 1'b1, 1'b0);
    checks++; if (imem_addr !== 64'd0) begin failures++; $display("FAIL rst_mid_pc: got %h want 0", imem_addr); end
    checks++; if (if_pc !== 64'd0 || if_instr !== 32'd0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ifid: got pc=%h instr=%h v=%b want all 0", if_pc, if_instr, if_valid);
    end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL rst_mid_count: got %0d want 0", fetch_count); end
    drive_cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    checks++; if (if_pc !== 64'd0 || if_valid !== 1'b1 || fetch_count !== 32'd1 || imem_addr !== 64'd4) begin
      failures++; $display("FAIL rst_mid_first: got pc=%h v=%b count=%0d addr=%h want pc=0 v=1 count=1 addr=4",
                           if_pc, if_valid, fetch_count, imem_addr);
    end
  endtask

  initial begin
    reset = 1'b1; PCSrc = 1'b0; PCBranch = '0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid_branch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
